trig_sync_debounce: RTL

TRIG_SYNC_DEBOUNCE -- requirements
Module: trig_sync_debounce

---
 rtl/trig_sync_debounce.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/trig_sync_debounce.sv
// trig_sync_debounce
//   Brings an asynchronous discriminator/trigger input into the clk domain,
//   debounces it, and turns each accepted rising edge into a one-cycle pulse.
//   After every accepted edge a holdoff window blocks further triggers.
//   Accepted triggers are counted in a saturating counter with a sticky
//   overflow flag.
//
// Ports
//   clk        in   system clock, all flops on the rising edge
//   reset      in   asynchronous, active-high reset
//   trig_in    in   raw asynchronous trigger input
//   enable     in   1 = accepted edges produce pulses and counts
//   clear_cnt  in   synchronous clear of event_cnt and overflow
//   trig_level out  debounced, synchronized trigger level (registered)
//   trig_pulse out  one-cycle pulse per accepted rising edge
//   busy       out  holdoff window active
//   event_cnt  out  accepted-trigger count, saturates at all-ones
//   overflow   out  sticky, set when a trigger arrives with event_cnt saturated
//
// Debounce FSM states
//   state        | meaning
//   ST_LOW       | level is 0, synchronized input stable low
//   ST_RISE_QUAL | level is 0, counting consecutive high samples
//   ST_HIGH      | level is 1, synchronized input stable high
//   ST_FALL_QUAL | level is 1, counting consecutive low samples

module trig_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trig_in,
    input  logic                 enable,
    input  logic                 clear_cnt,
    output logic                 trig_level,
    output logic                 trig_pulse,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] event_cnt,
    output logic                 overflow
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    // dcnt value at which the next agreeing sample is the DEBOUNCE_CYCLES-th
    localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DCNT_FIRST = DW'(1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLDOFF_CYCLES);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_QUAL = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_QUAL = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer: the only logic that touches trig_in
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic            level_q, level_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOW;
            dcnt_q  <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_LOW: begin
                if (s) begin
                    // With a single-sample debounce the first high sample
                    // already qualifies, so the qualifying state is skipped.
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ST_HIGH;
                        dcnt_d  = '0;
                    end else begin
                        state_d = ST_RISE_QUAL;
                        dcnt_d  = DCNT_FIRST;
                    end
                end
            end
            ST_RISE_QUAL: begin
                if (!s) begin
                    state_d = ST_LOW;
                    dcnt_d  = '0;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = ST_HIGH;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d  = dcnt_q + DW'(1);
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = ST_LOW;
                        dcnt_d  = '0;
                    end else begin
                        state_d = ST_FALL_QUAL;
                        dcnt_d  = DCNT_FIRST;
                    end
                end
            end
            ST_FALL_QUAL: begin
                if (s) begin
                    state_d = ST_HIGH;
                    dcnt_d  = '0;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = ST_LOW;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d  = dcnt_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                dcnt_d  = '0;
            end
        endcase
    end

    // Level is decoded from the next state so the registered copy changes
    // on the same edge the FSM enters HIGH / LOW.
    assign level_d    = (state_d == ST_HIGH) || (state_d == ST_FALL_QUAL);
    assign trig_level = level_q;

    // ------------------------------------------------------------------
    // Edge acceptance and holdoff (down-counter, busy while non-zero)
    // ------------------------------------------------------------------
    logic          rise;
    logic          accept;
    logic [HW-1:0] hcnt_q;
    logic          pulse_q;

    assign rise   = level_d & ~level_q;
    assign accept = rise & enable & ~busy;
    assign busy   = (hcnt_q != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= accept;
            if (accept) begin
                hcnt_q <= HOLD_LOAD;
            end else if (busy) begin
                hcnt_q <= hcnt_q - HW'(1);
            end
        end
    end

    assign trig_pulse = pulse_q;

    // ------------------------------------------------------------------
    // Saturating event counter; clear has priority over a coincident pulse
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear_cnt) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            if (&cnt_q) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign event_cnt = cnt_q;
    assign overflow  = ovf_q;

endmodule
